kf8088_bus_cycle_generator: RTL

Initiator side of the 8088 status bus. Takes single bus-cycle requests from the CPU core and runs T1–T4 machine cycles, with READY-driven wait states. During each cycle it drives the S2..S0 status code, address and write data, and captures read data. Its processor_status output feeds the 8288-like bus controller, which decodes it into ALE, DT/R, DEN and command strobes.

---
 rtl/kf8088_bus_cycle_generator.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/kf8088_bus_cycle_generator.sv
// -----------------------------------------------------------------------------
// kf8088_bus_cycle_generator
//
// Initiator side of the 8088 status bus. Accepts one bus-cycle request at a
// time from the CPU core and sequences it through T1..T4 machine cycles, with
// READY-driven wait states (TW). It drives the S2..S0 status code that the
// 8288-like bus controller decodes, plus the bus address and write data, and
// captures read data at the end of read-type cycles.
//
// Ports:
//   clock            system clock, all state updates on its rising edge
//   reset_n          asynchronous active-low reset
//   cpu_clock        CPU clock level, sampled on clock (edges found internally)
//   req_valid        request present, fields held until req_ready
//   req_status       S2..S0 of the requested cycle (3'b111 never accepted)
//   req_address      cycle address
//   req_write_data   data for write cycles
//   req_ready        one-clock pulse on request acceptance
//   rsp_valid        one-clock pulse on cycle completion
//   rsp_read_data    data of the last read-type cycle, held between captures
//   ready            bus READY (already synchronised)
//   bus_data_in      bus read data
//   processor_status S2..S0 to the bus controller
//   bus_address      cycle address on the bus
//   bus_data_out     write data on the bus
//   bus_data_oe      write data drive enable
//   bus_state        TI=0, T1=1, T2=2, T3=3, TW=4, T4=5
// -----------------------------------------------------------------------------
module kf8088_bus_cycle_generator #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cpu_clock,
    input  logic                     req_valid,
    input  logic [2:0]               req_status,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_write_data,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_read_data,
    input  logic                     ready,
    input  logic [DATA_WIDTH-1:0]    bus_data_in,
    output logic [2:0]               processor_status,
    output logic [ADDRESS_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0]    bus_data_out,
    output logic                     bus_data_oe,
    output logic [2:0]               bus_state
);

    typedef enum logic [2:0] {
        ST_TI = 3'd0,
        ST_T1 = 3'd1,
        ST_T2 = 3'd2,
        ST_T3 = 3'd3,
        ST_TW = 3'd4,
        ST_T4 = 3'd5
    } bus_state_t;

    localparam logic [2:0] STATUS_PASSIVE = 3'b111;

    // Write-type status codes: 010 (IO write) and 110 (memory write).
    function automatic logic is_write_f(input logic [2:0] status);
        return (status == 3'b010) || (status == 3'b110);
    endfunction

    // Halt cycle has no data phase and ends after T2.
    function automatic logic is_halt_f(input logic [2:0] status);
        return (status == 3'b011);
    endfunction

    // Read-type codes: INTA 000, IO read 001, code fetch 100, memory read 101.
    function automatic logic is_read_f(input logic [2:0] status);
        return (status == 3'b000) || (status == 3'b001) ||
               (status == 3'b100) || (status == 3'b101);
    endfunction

    bus_state_t                 state_r, state_s;
    logic                       prev_cpu_clock_r;
    logic                       pending_r, pending_s;
    logic [2:0]                 lat_status_r, lat_status_s;
    logic [ADDRESS_WIDTH-1:0]   lat_address_r, lat_address_s;
    logic [DATA_WIDTH-1:0]      lat_data_r, lat_data_s;
    logic                       ready_q_r, ready_q_s;
    logic [2:0]                 status_r, status_s;
    logic [ADDRESS_WIDTH-1:0]   bus_address_r, bus_address_s;
    logic [DATA_WIDTH-1:0]      bus_data_out_r, bus_data_out_s;
    logic                       bus_data_oe_r, bus_data_oe_s;
    logic                       req_ready_r, req_ready_s;
    logic                       rsp_valid_r, rsp_valid_s;
    logic [DATA_WIDTH-1:0]      rsp_read_data_r, rsp_read_data_s;

    logic                       pos_event_s;
    logic                       neg_event_s;
    logic                       accept_s;

    assign pos_event_s = ~prev_cpu_clock_r & cpu_clock;
    assign neg_event_s = prev_cpu_clock_r & ~cpu_clock;
    // pending guard keeps a second posedge in the same TI from re-latching.
    assign accept_s    = req_valid & (req_status != STATUS_PASSIVE) & ~pending_r;

    assign bus_state        = state_r;
    assign processor_status = status_r;
    assign bus_address      = bus_address_r;
    assign bus_data_out     = bus_data_out_r;
    assign bus_data_oe      = bus_data_oe_r;
    assign req_ready        = req_ready_r;
    assign rsp_valid        = rsp_valid_r;
    assign rsp_read_data    = rsp_read_data_r;

    // Next-state and next-output logic: posedge events drive status and
    // acceptance, negedge events move the T-state sequencer.
    always_comb begin
        state_s         = state_r;
        pending_s       = pending_r;
        lat_status_s    = lat_status_r;
        lat_address_s   = lat_address_r;
        lat_data_s      = lat_data_r;
        ready_q_s       = ready_q_r;
        status_s        = status_r;
        bus_address_s   = bus_address_r;
        bus_data_out_s  = bus_data_out_r;
        bus_data_oe_s   = bus_data_oe_r;
        req_ready_s     = 1'b0;
        rsp_valid_s     = 1'b0;
        rsp_read_data_s = rsp_read_data_r;

        if (pos_event_s) begin
            case (state_r)
                ST_TI, ST_T4: begin
                    // Status goes active here, half a CPU clock before T1.
                    if (accept_s) begin
                        lat_status_s  = req_status;
                        lat_address_s = req_address;
                        lat_data_s    = req_write_data;
                        status_s      = req_status;
                        req_ready_s   = 1'b1;
                        pending_s     = 1'b1;
                    end else begin
                        pending_s     = pending_r;
                    end
                end
                ST_T2: begin
                    if (is_halt_f(lat_status_r)) begin
                        status_s = STATUS_PASSIVE;
                    end else begin
                        status_s = status_r;
                    end
                end
                ST_T3, ST_TW: begin
                    // READY high means the cycle ends at the next negedge,
                    // so the status returns to passive right away.
                    ready_q_s = ready;
                    if (ready) begin
                        status_s = STATUS_PASSIVE;
                    end else begin
                        status_s = status_r;
                    end
                end
                default: begin
                    status_s = status_r;
                end
            endcase
        end else if (neg_event_s) begin
            case (state_r)
                ST_TI: begin
                    if (pending_r) begin
                        state_s       = ST_T1;
                        bus_address_s = lat_address_r;
                        pending_s     = 1'b0;
                    end else begin
                        state_s       = ST_TI;
                    end
                end
                ST_T1: begin
                    state_s = ST_T2;
                    if (is_write_f(lat_status_r)) begin
                        bus_data_out_s = lat_data_r;
                        bus_data_oe_s  = 1'b1;
                    end else begin
                        bus_data_oe_s  = 1'b0;
                    end
                end
                ST_T2: begin
                    if (is_halt_f(lat_status_r)) begin
                        state_s     = ST_TI;
                        rsp_valid_s = 1'b1;
                    end else begin
                        state_s     = ST_T3;
                    end
                end
                ST_T3, ST_TW: begin
                    if (ready_q_r) begin
                        state_s     = ST_T4;
                        rsp_valid_s = 1'b1;
                        if (is_read_f(lat_status_r)) begin
                            rsp_read_data_s = bus_data_in;
                        end else begin
                            rsp_read_data_s = rsp_read_data_r;
                        end
                    end else begin
                        state_s = ST_TW;
                    end
                end
                ST_T4: begin
                    bus_data_oe_s = 1'b0;
                    // A request accepted at the T4 posedge chains straight into T1.
                    if (pending_r) begin
                        state_s       = ST_T1;
                        bus_address_s = lat_address_r;
                        pending_s     = 1'b0;
                    end else begin
                        state_s       = ST_TI;
                    end
                end
                default: begin
                    state_s       = ST_TI;
                    status_s      = STATUS_PASSIVE;
                    bus_data_oe_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_TI;
            prev_cpu_clock_r <= 1'b0;
            pending_r        <= 1'b0;
            lat_status_r     <= STATUS_PASSIVE;
            lat_address_r    <= {ADDRESS_WIDTH{1'b0}};
            lat_data_r       <= {DATA_WIDTH{1'b0}};
            ready_q_r        <= 1'b0;
            status_r         <= STATUS_PASSIVE;
            bus_address_r    <= {ADDRESS_WIDTH{1'b0}};
            bus_data_out_r   <= {DATA_WIDTH{1'b0}};
            bus_data_oe_r    <= 1'b0;
            req_ready_r      <= 1'b0;
            rsp_valid_r      <= 1'b0;
            rsp_read_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r          <= state_s;
            prev_cpu_clock_r <= cpu_clock;
            pending_r        <= pending_s;
            lat_status_r     <= lat_status_s;
            lat_address_r    <= lat_address_s;
            lat_data_r       <= lat_data_s;
            ready_q_r        <= ready_q_s;
            status_r         <= status_s;
            bus_address_r    <= bus_address_s;
            bus_data_out_r   <= bus_data_out_s;
            bus_data_oe_r    <= bus_data_oe_s;
            req_ready_r      <= req_ready_s;
            rsp_valid_r      <= rsp_valid_s;
            rsp_read_data_r  <= rsp_read_data_s;
        end
    end

endmodule
